prt_scaler_vout: RTL and testbench

- Video output stage, directly downstream of the scaler timing generator.
- Buffers scaled pixel words from the scaler datapath in a small synchronous FIFO.
- Pops one word per active (DE) clock of the timing generator and drives the aligned top-level video bus (VS/HS/DE/data).
- Detects underflow and frame misalignment; re-locks automatically at the next frame start.

---
 rtl/prt_scaler_vout_pkg.sv | 26 ++
 rtl/prt_scaler_lib_edge.sv | 20 ++
 rtl/prt_scaler_vout_fifo.sv | 74 +++++++
 rtl/prt_scaler_vout.sv | 168 ++++++++++++++++
 tb/tb_prt_scaler_vout.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prt_scaler_vout_pkg.sv
// Shared types and constants for the scaler video output stage.
package prt_scaler_vout_pkg;

    localparam int unsigned C_PPC       = 4;
    localparam int unsigned C_BPC       = 8;
    localparam int unsigned C_WORD_W    = C_PPC * 3 * C_BPC;
    localparam int unsigned C_FIFO_WRDS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } vout_state_t;

    // One buffered pixel word plus its start-of-frame marker.
    typedef struct packed {
        logic                sof;
        logic [C_WORD_W-1:0] data;
    } vout_word_t;

    // Width of an occupancy counter that can hold 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prt_scaler_lib_edge.sv
// Rising-edge detector; samples the input only on enabled clocks.
module prt_scaler_lib_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cke,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Remember the level seen on the previous enabled clock.
    always_ff @(posedge i_clk) begin
        if (i_rst)      r_prev <= 1'b0;
        else if (i_cke) r_prev <= i_sig;
    end

    assign o_rise = i_cke & i_sig & ~r_prev;

endmodule

// File: rtl/prt_scaler_vout_fifo.sv
// Synchronous word FIFO with a registered head word and a flush input.
// A word written into an empty FIFO becomes visible on the next clock.
module prt_scaler_vout_fifo
    import prt_scaler_vout_pkg::*;
#(
    parameter int unsigned P_WRDS = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_wr,
    input  vout_word_t              i_wdat,
    input  logic                    i_rd,
    output vout_word_t              o_head,
    output logic                    o_empty,
    output logic [cnt_w(P_WRDS)-1:0] o_count
);

    localparam int unsigned L_AW = $clog2(P_WRDS);
    localparam int unsigned L_CW = cnt_w(P_WRDS);

    vout_word_t        r_mem [P_WRDS];
    vout_word_t        r_head;
    logic [L_AW-1:0]   r_wr_ptr;
    logic [L_AW-1:0]   r_rd_ptr;
    logic [L_CW-1:0]   r_count;

    logic              w_full;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [L_AW-1:0]   w_rd_ptr_nxt;

    assign w_full       = (r_count == L_CW'(P_WRDS));
    assign o_empty      = (r_count == '0);
    assign w_wr_en      = i_wr & ~w_full;
    assign w_rd_en      = i_rd & ~o_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    // Pointers and occupancy; flush wins over any access in the same clock.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= w_rd_ptr_nxt;
            if (w_wr_en && !w_rd_en)      r_count <= r_count + 1'b1;
            else if (w_rd_en && !w_wr_en) r_count <= r_count - 1'b1;
        end
    end

    // Storage array; not reset, occupancy says which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_wdat;
    end

    // Head register: next entry on a pop, the incoming word when the
    // FIFO is (or is about to become) empty, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
        end else if (w_rd_en) begin
            if (r_count == L_CW'(1)) r_head <= i_wdat;
            else                     r_head <= r_mem[w_rd_ptr_nxt];
        end else if (o_empty && w_wr_en) begin
            r_head <= i_wdat;
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/prt_scaler_vout.sv
// Video output stage: buffers scaled words and aligns them to the
// timing generator's DE, with underflow/misalignment detect and re-lock.
module prt_scaler_vout
    import prt_scaler_vout_pkg::*;
#(
    parameter int unsigned P_PPC       = C_PPC,
    parameter int unsigned P_BPC       = C_BPC,
    parameter int unsigned P_FIFO_WRDS = C_FIFO_WRDS
) (
    input  logic                     CLK_IN,
    input  logic                     RST_IN,
    input  logic                     CKE_IN,
    input  logic                     CTL_RUN_IN,
    input  logic                     TG_VS_IN,
    input  logic                     TG_HS_IN,
    input  logic                     TG_DE_IN,
    input  logic [P_PPC*3*P_BPC-1:0] SRC_DAT_IN,
    input  logic                     SRC_SOF_IN,
    input  logic                     SRC_VLD_IN,
    output logic                     SRC_RDY_OUT,
    output logic                     VID_VS_OUT,
    output logic                     VID_HS_OUT,
    output logic                     VID_DE_OUT,
    output logic [P_PPC*3*P_BPC-1:0] VID_DAT_OUT,
    output logic                     STA_LOCK_OUT,
    output logic                     STA_UFL_OUT
);

    localparam int unsigned L_DW = P_PPC * 3 * P_BPC;
    localparam int unsigned L_CW = cnt_w(P_FIFO_WRDS);

    vout_state_t     r_state;
    logic            r_first_de;
    logic            r_ufl;
    logic            r_vs;
    logic            r_hs;
    logic            r_de;
    logic [L_DW-1:0] r_dat;

    vout_state_t     w_nxt_state;
    logic            w_first_de_nxt;
    logic            w_ufl_set;
    logic            w_pop;
    logic            w_de_nxt;
    logic [L_DW-1:0] w_dat_nxt;

    vout_word_t      w_wdat;
    vout_word_t      w_head;
    logic            w_empty;
    logic [L_CW-1:0] w_count;
    logic            w_full;
    logic            w_wr;
    logic            w_flush;
    logic            w_vs_rise;

    // Ready comes only from registered state, never from SRC_VLD_IN.
    assign w_full      = (w_count == L_CW'(P_FIFO_WRDS));
    assign SRC_RDY_OUT = CTL_RUN_IN & (r_state != IDLE) & ~w_full;
    assign w_wr        = SRC_VLD_IN & SRC_RDY_OUT;
    assign w_flush     = ~CTL_RUN_IN | (r_state == IDLE);
    assign w_wdat.sof  = SRC_SOF_IN;
    assign w_wdat.data = SRC_DAT_IN;

    prt_scaler_vout_fifo #(
        .P_WRDS (P_FIFO_WRDS)
    ) u_fifo (
        .i_clk   (CLK_IN),
        .i_rst   (RST_IN),
        .i_flush (w_flush),
        .i_wr    (w_wr),
        .i_wdat  (w_wdat),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    prt_scaler_lib_edge u_vs_edge (
        .i_clk  (CLK_IN),
        .i_rst  (RST_IN),
        .i_cke  (CKE_IN),
        .i_sig  (TG_VS_IN),
        .o_rise (w_vs_rise)
    );

    // Next state, pop decision and next video word for this enabled clock.
    always_comb begin
        w_nxt_state    = r_state;
        w_first_de_nxt = r_first_de;
        w_ufl_set      = 1'b0;
        w_pop          = 1'b0;
        w_de_nxt       = 1'b0;
        w_dat_nxt      = '0;
        if (CTL_RUN_IN && CKE_IN) begin
            case (r_state)
                IDLE: w_nxt_state = SYNC;
                SYNC: begin
                    // Drop words until a frame start sits at the head,
                    // then hold it until the next VS edge.
                    if (!w_empty && !w_head.sof) begin
                        w_pop = 1'b1;
                    end else if (!w_empty && w_vs_rise) begin
                        w_nxt_state    = ACTIVE;
                        w_first_de_nxt = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (TG_DE_IN && w_empty) begin
                        // Underflow beats a coincident VS edge.
                        w_ufl_set   = 1'b1;
                        w_nxt_state = SYNC;
                    end else begin
                        if (TG_DE_IN) begin
                            w_de_nxt       = 1'b1;
                            w_dat_nxt      = w_head.data;
                            w_first_de_nxt = 1'b0;
                            if (w_head.sof && !r_first_de) begin
                                // Early frame start: show it but keep it at
                                // the head so SYNC can re-lock on it.
                                w_ufl_set   = 1'b1;
                                w_nxt_state = SYNC;
                            end else begin
                                w_pop = 1'b1;
                                if (!w_head.sof && r_first_de) begin
                                    w_ufl_set   = 1'b1;
                                    w_nxt_state = SYNC;
                                end
                            end
                        end
                        if (w_vs_rise) w_first_de_nxt = 1'b1;
                    end
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    // State, sticky error and output registers; run low clears at once.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN || !CTL_RUN_IN) begin
            r_state    <= IDLE;
            r_first_de <= 1'b0;
            r_ufl      <= 1'b0;
            r_vs       <= 1'b0;
            r_hs       <= 1'b0;
            r_de       <= 1'b0;
            r_dat      <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_first_de <= w_first_de_nxt;
            if (w_ufl_set) r_ufl <= 1'b1;
            if (CKE_IN) begin
                r_vs  <= TG_VS_IN;
                r_hs  <= TG_HS_IN;
                r_de  <= w_de_nxt;
                r_dat <= w_dat_nxt;
            end
        end
    end

    assign VID_VS_OUT   = r_vs;
    assign VID_HS_OUT   = r_hs;
    assign VID_DE_OUT   = r_de;
    assign VID_DAT_OUT  = r_dat;
    assign STA_LOCK_OUT = (r_state == ACTIVE);
    assign STA_UFL_OUT  = r_ufl;

endmodule

// File: tb/tb_prt_scaler_vout.sv
// Randomized bench for prt_scaler_vout with a queue-based reference
// model feeding a scoreboard that a separate monitor drains.
module tb_prt_scaler_vout;

    localparam int DW = 96;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst, cke, run, tg_vs, tg_hs, tg_de, sof, vld;
    logic [DW-1:0] dat;
    logic          rdy, vid_vs, vid_hs, vid_de, lock, ufl;
    logic [DW-1:0] vid_dat;

    always #5 clk = ~clk;

    prt_scaler_vout dut (
        .CLK_IN       (clk),
        .RST_IN       (rst),
        .CKE_IN       (cke),
        .CTL_RUN_IN   (run),
        .TG_VS_IN     (tg_vs),
        .TG_HS_IN     (tg_hs),
        .TG_DE_IN     (tg_de),
        .SRC_DAT_IN   (dat),
        .SRC_SOF_IN   (sof),
        .SRC_VLD_IN   (vld),
        .SRC_RDY_OUT  (rdy),
        .VID_VS_OUT   (vid_vs),
        .VID_HS_OUT   (vid_hs),
        .VID_DE_OUT   (vid_de),
        .VID_DAT_OUT  (vid_dat),
        .STA_LOCK_OUT (lock),
        .STA_UFL_OUT  (ufl)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct { bit sof; logic [DW-1:0] data; } mword_t;
    typedef struct { bit vs, hs, de, lock, ufl; logic [DW-1:0] dat; } exp_t;

    mword_t mq[$];
    exp_t   exp_q[$];
    exp_t   m_out = '{0, 0, 0, 0, 0, '0};
    int     m_mode = 0;          // 0 idle, 1 waiting for frame start, 2 streaming
    bit     m_first = 0, m_ufl = 0, m_prev_vs = 0;
    bit     model_on = 0, mon_on = 0;

    function automatic bit m_rdy();
        return run && (m_mode != 0) && (mq.size() < D);
    endfunction

    always @(posedge clk) begin
        if (model_on) begin
            bit     wr, rise;
            mword_t nw, h;
            wr      = vld && m_rdy();
            nw.sof  = sof;
            nw.data = dat;
            rise    = cke && tg_vs && !m_prev_vs;
            if (!run) begin
                m_mode  = 0;
                mq.delete();
                m_ufl   = 0;
                m_first = 0;
                m_out   = '{0, 0, 0, 0, 0, '0};
            end else if (cke) begin
                m_out.vs  = tg_vs;
                m_out.hs  = tg_hs;
                m_out.de  = 0;
                m_out.dat = '0;
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (mq.size() > 0 && !mq[0].sof) void'(mq.pop_front());
                    else if (mq.size() > 0 && rise) begin m_mode = 2; m_first = 1; end
                end else begin
                    if (tg_de && mq.size() == 0) begin
                        m_ufl  = 1;
                        m_mode = 1;
                    end else begin
                        if (tg_de) begin
                            h         = mq[0];
                            m_out.de  = 1;
                            m_out.dat = h.data;
                            if (h.sof != m_first) begin m_ufl = 1; m_mode = 1; end
                            if (!(h.sof && !m_first)) void'(mq.pop_front());
                            m_first = 0;
                        end
                        if (rise) m_first = 1;
                    end
                end
            end
            if (cke) m_prev_vs = tg_vs;
            if (wr) mq.push_back(nw);
            m_out.lock = (m_mode == 2);
            m_out.ufl  = m_ufl;
            exp_q.push_back(m_out);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_underrun: no expected entry for DUT output at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                n_tests++;
                if ({vid_vs, vid_hs, vid_de} !== {e.vs, e.hs, e.de}) begin
                    n_fail++;
                    $display("FAIL vid_sync @%0t: got vs/hs/de=%b%b%b want %b%b%b",
                             $time, vid_vs, vid_hs, vid_de, e.vs, e.hs, e.de);
                end
                n_tests++;
                if (vid_dat !== e.dat) begin
                    n_fail++;
                    $display("FAIL vid_dat @%0t: got %h want %h", $time, vid_dat, e.dat);
                end
                n_tests++;
                if ({lock, ufl} !== {e.lock, e.ufl}) begin
                    n_fail++;
                    $display("FAIL status @%0t: got lock/ufl=%b%b want %b%b",
                             $time, lock, ufl, e.lock, e.ufl);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int  tg_px = 0, tg_ln = 1;
    bit  tg_hold = 0;
    int  src_idx = 0, src_len = 32;
    bit  len_jitter = 0, took = 0;
    int  vld_rate = 90, cke_rate = 100;

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int next_len();
        if (!len_jitter) return 32;
        case ($urandom_range(2))
            0:       return 28;
            1:       return 36;
            default: return 32;
        endcase
    endfunction

    task automatic drive_tg();
        tg_vs = (tg_ln == 0);
        tg_hs = (tg_px < 2);
        tg_de = (tg_ln >= 2) && (tg_px >= 4) && (tg_px < 12);
    endtask

    // One clock: advance TG and source from what the last edge consumed,
    // then present fresh inputs and check ready against the model.
    task automatic cyc();
        @(negedge clk);
        if (cke && !(tg_hold && !tg_de)) begin
            tg_px++;
            if (tg_px == 14) begin tg_px = 0; tg_ln = (tg_ln + 1) % 6; end
        end
        if (took) begin
            src_idx++;
            if (src_idx >= src_len) begin src_idx = 0; src_len = next_len(); end
            dat = rnd_word();
        end
        cke = ($urandom_range(99) < cke_rate);
        vld = ($urandom_range(99) < vld_rate);
        sof = (src_idx == 0);
        drive_tg();
        #1;
        took = vld && rdy;
        if (model_on) begin
            n_tests++;
            if (rdy !== m_rdy()) begin
                n_fail++;
                $display("FAIL src_rdy @%0t: got %b want %b", $time, rdy, m_rdy());
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit found;
        rst = 1; run = 1; cke = 1; vld = 1; sof = 1;
        dat = rnd_word();
        drive_tg();
        repeat (4) @(negedge clk);
        // Reset holds everything low even with run and valid asserted.
        n_tests++;
        if ({rdy, vid_vs, vid_hs, vid_de, lock, ufl} !== 6'b0 || vid_dat !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy/vs/hs/de/lock/ufl=%b%b%b%b%b%b dat=%h want all 0",
                     rdy, vid_vs, vid_hs, vid_de, lock, ufl, vid_dat);
        end
        rst = 0; run = 0; vld = 0;
        model_on = 1;
        @(posedge clk);
        #1 mon_on = 1;
        run_cycles(5);

        // Clean lock and streaming.
        run = 1; vld_rate = 90; cke_rate = 100;
        run_cycles(400);
        // Random clock enable, then a stretch with the enable held low.
        cke_rate = 70;
        run_cycles(300);
        cke_rate = 0;
        run_cycles(20);
        cke_rate = 70;
        run_cycles(200);
        // Starved source: underflow and re-lock.
        cke_rate = 100; vld_rate = 25;
        run_cycles(400);
        vld_rate = 90;
        run_cycles(300);
        // Frames of the wrong length: misalignment and re-lock.
        len_jitter = 1;
        run_cycles(500);
        len_jitter = 0;
        run_cycles(400);
        // Backpressure: stall the timing generator in blanking.
        tg_hold = 1; vld_rate = 100;
        run_cycles(60);
        tg_hold = 0; vld_rate = 90;
        run_cycles(300);

        // Run dropped mid-line, source restarts mid-frame (discard path).
        for (int k = 0; k < 3; k++) begin
            found = 0;
            for (int i = 0; i < 300 && !found; i++) begin
                cyc();
                if (tg_de && lock) found = 1;
            end
            n_tests++;
            if (!found) begin
                n_fail++;
                $display("FAIL wait_de_timeout: got no locked DE within 300 clocks, want one");
            end
            run = 0;
            cke_rate = (k == 1) ? 0 : 50;
            run_cycles(3);
            run = 1;
            cke_rate = 70;
            src_idx = $urandom_range(31, 1);
            src_len = 32;
            run_cycles(400);
        end

        @(posedge clk);
        #1 model_on = 0;
        @(negedge clk);
        #1 mon_on = 0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d leftover entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
